// File: rtl/manchester_tx.sv
// rtl/manchester_tx.sv - Manchester (IEEE 802.3) framed byte transmitter
// Preamble + payload bytes per frame, one-entry holding register, forced idle gap.
module manchester_tx #(
  parameter int unsigned SPC       = 4,
  parameter int unsigned PRE_LEN   = 16,
  parameter logic [31:0] PREAMBLE  = 32'h0000_F0B5,
  parameter int unsigned GAP_CHIPS = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_data,
  input  logic              i_valid,
  input  logic              i_last,
  output logic              o_ready,
  output logic              o_chip,
  output logic signed [1:0] o_symbol,
  output logic              o_sym_valid,
  output logic              o_busy,
  output logic              o_underrun
);

  localparam int unsigned GAP_LEN  = GAP_CHIPS * SPC;
  localparam logic [31:0] PRE_INIT = PREAMBLE << (32 - PRE_LEN);
  localparam logic [7:0]  SAMP_MAX = 8'(SPC - 1);
  localparam logic [4:0]  PRE_MAX  = 5'(PRE_LEN - 1);
  localparam logic [15:0] GAP_MAX  = 16'(GAP_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_GAP} state_t;

  state_t      state;
  logic [7:0]  hold_data;
  logic        hold_last;
  logic        hold_full;
  logic [7:0]  shreg;
  logic        cur_last;
  logic [31:0] pre_sh;
  logic [7:0]  samp_cnt;
  logic        half;
  logic [4:0]  bit_cnt;
  logic [15:0] gap_cnt;
  logic        underrun_pend;

  logic chip_end;
  logic bit_end;
  logic cur_bit;
  logic line;

  assign chip_end = (samp_cnt == SAMP_MAX);
  assign bit_end  = chip_end && half;
  assign cur_bit  = (state == S_PRE) ? pre_sh[31] : shreg[7];
  // First half carries the complement, second half the bit itself.
  assign line     = half ? cur_bit : ~cur_bit;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= S_IDLE;
      hold_data     <= 8'h00;
      hold_last     <= 1'b0;
      hold_full     <= 1'b0;
      shreg         <= 8'h00;
      cur_last      <= 1'b0;
      pre_sh        <= 32'h0;
      samp_cnt      <= 8'h00;
      half          <= 1'b0;
      bit_cnt       <= 5'd0;
      gap_cnt       <= 16'h0;
      underrun_pend <= 1'b0;
      o_ready       <= 1'b1;
      o_chip        <= 1'b0;
      o_symbol      <= 2'b00;
      o_sym_valid   <= 1'b0;
      o_busy        <= 1'b0;
      o_underrun    <= 1'b0;
    end else begin
      o_underrun    <= underrun_pend;
      underrun_pend <= 1'b0;

      // o_ready mirrors ~hold_full, so accept and unload never coincide.
      if (i_valid && o_ready) begin
        hold_data <= i_data;
        hold_last <= i_last;
        hold_full <= 1'b1;
        o_ready   <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (hold_full) begin
            state  <= S_PRE;
            pre_sh <= PRE_INIT;
            o_busy <= 1'b1;
          end
        end
        S_PRE, S_DATA: begin
          if (chip_end) begin
            samp_cnt <= 8'h00;
            half     <= ~half;
          end else begin
            samp_cnt <= samp_cnt + 8'd1;
          end
          if (bit_end) begin
            if (state == S_PRE) begin
              if (bit_cnt == PRE_MAX) begin
                state     <= S_DATA;
                bit_cnt   <= 5'd0;
                shreg     <= hold_data;
                cur_last  <= hold_last;
                hold_full <= 1'b0;
                o_ready   <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
                pre_sh  <= pre_sh << 1;
              end
            end else if (bit_cnt == 5'd7) begin
              bit_cnt <= 5'd0;
              if (cur_last) begin
                state   <= S_GAP;
                gap_cnt <= 16'h0;
              end else if (hold_full) begin
                shreg     <= hold_data;
                cur_last  <= hold_last;
                hold_full <= 1'b0;
                o_ready   <= 1'b1;
              end else begin
                underrun_pend <= 1'b1;
                state         <= S_GAP;
                gap_cnt       <= 16'h0;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
              shreg   <= shreg << 1;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_MAX) begin
            if (hold_full) begin
              state  <= S_PRE;
              pre_sh <= PRE_INIT;
            end else begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
      endcase

      // Line outputs are a registered image of the current state/counters.
      if (state == S_PRE || state == S_DATA) begin
        o_chip      <= line;
        o_symbol    <= {~line, 1'b1};
        o_sym_valid <= 1'b1;
      end else begin
        o_chip      <= 1'b0;
        o_symbol    <= 2'b00;
        o_sym_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_manchester_tx.sv
// tb/tb_manchester_tx.sv - randomized self-checking bench for manchester_tx
// Expected chip streams are built from the line-code rules, not from the RTL.
module tb_manchester_tx;

  localparam logic [31:0] PRE_PAT = 32'h0000_F0B5;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i_data;
  logic       i_valid, i_last;
  logic       o_ready, o_chip, o_sym_valid, o_busy, o_underrun;
  logic [1:0] o_symbol;
  logic [7:0] b_data;
  logic       b_valid, b_last;
  logic       b_ready, b_chip, b_sym_valid, b_busy, b_underrun;
  logic [1:0] b_symbol;

  always #5 clk = ~clk;

  manchester_tx dut (
    .i_clk(clk), .i_rst(rst), .i_data(i_data), .i_valid(i_valid), .i_last(i_last),
    .o_ready(o_ready), .o_chip(o_chip), .o_symbol(o_symbol), .o_sym_valid(o_sym_valid),
    .o_busy(o_busy), .o_underrun(o_underrun)
  );

  manchester_tx #(.SPC(2), .PRE_LEN(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_data(b_data), .i_valid(b_valid), .i_last(b_last),
    .o_ready(b_ready), .o_chip(b_chip), .o_symbol(b_symbol), .o_sym_valid(b_sym_valid),
    .o_busy(b_busy), .o_underrun(b_underrun)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int ncyc = 0;
  bit in_run = 0;
  int run_len = 0;
  bit chips_q[$];
  int runs_q[$];
  int start_q[$];
  int end_q[$];
  int und_q[$];
  bit b_in_run = 0;
  int b_len = 0;
  bit b_chips[$];
  int b_runs[$];
  bit exp_q[$];

  always @(negedge clk) begin
    if (o_sym_valid) begin
      if (!in_run) begin
        start_q.push_back(ncyc);
        run_len = 0;
        in_run = 1;
      end
      chips_q.push_back(o_chip);
      run_len++;
      check("symbol", {30'b0, o_symbol}, {30'b0, ~o_chip, 1'b1});
    end else begin
      if (in_run) begin
        runs_q.push_back(run_len);
        end_q.push_back(ncyc - 1);
        in_run = 0;
      end
      check("idle_line", {29'b0, o_chip, o_symbol}, 32'h0);
    end
    if (o_underrun) und_q.push_back(ncyc);
    if (b_sym_valid) begin
      if (!b_in_run) begin
        b_len = 0;
        b_in_run = 1;
      end
      b_chips.push_back(b_chip);
      b_len++;
      check("b_symbol", {30'b0, b_symbol}, {30'b0, ~b_chip, 1'b1});
    end else if (b_in_run) begin
      b_runs.push_back(b_len);
      b_in_run = 0;
    end
    ncyc++;
  end

  task automatic push_bit(input bit b, input int spc);
    repeat (spc) exp_q.push_back(~b);
    repeat (spc) exp_q.push_back(b);
  endtask

  task automatic build_exp(input logic [7:0] bytes[$], input int pre_len, input int spc);
    exp_q.delete();
    for (int i = pre_len - 1; i >= 0; i--) push_bit(PRE_PAT[i], spc);
    foreach (bytes[k])
      for (int j = 7; j >= 0; j--) push_bit(bytes[k][j], spc);
  endtask

  task automatic cmp_chips(input string tag, input bit got[$]);
    check({tag, "_nchips"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      check({tag, "_chip"}, {31'b0, got[i]}, {31'b0, exp_q[i]});
      if (got[i] !== exp_q[i]) break;
    end
  endtask

  task automatic clear_runs();
    chips_q.delete(); runs_q.delete(); start_q.delete(); end_q.delete();
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit last, output int hs);
    int t = 0;
    @(negedge clk);
    while (!o_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait", {31'b0, o_ready}, 1);
    i_data = d; i_last = last; i_valid = 1'b1;
    @(posedge clk);
    #1;
    hs = ncyc;
    i_valid = 1'b0; i_last = 1'b0; i_data = 8'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    repeat (4) tick();
    while ((o_busy || in_run || !o_ready) && t < 5000) begin
      tick();
      t++;
    end
    check("idle_wait", {30'b0, o_busy, in_run}, 32'h0);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] bytes[$], input bit last_flag);
    int hs, hs0;
    hs0 = 0;
    clear_runs();
    und_q.delete();
    foreach (bytes[k]) begin
      send_byte(bytes[k], last_flag && (k == bytes.size() - 1), hs);
      if (k == 0) hs0 = hs;
    end
    wait_idle();
    build_exp(bytes, 16, 4);
    check({tag, "_runs"}, runs_q.size(), 1);
    if (runs_q.size() > 0) begin
      check({tag, "_len"}, runs_q[0], (16 + 8 * bytes.size()) * 8);
      check({tag, "_start"}, start_q[0], hs0 + 2);
    end
    cmp_chips(tag, chips_q);
    check({tag, "_underruns"}, und_q.size(), last_flag ? 0 : 1);
    if (!last_flag && und_q.size() > 0 && end_q.size() > 0)
      check({tag, "_und_cycle"}, und_q[0], end_q[0] + 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bq[$];
    bit tmp_q[$];
    logic [7:0] a, b;
    int hs, t, n;

    i_data = 8'h00; i_valid = 1'b0; i_last = 1'b0;
    b_data = 8'h00; b_valid = 1'b0; b_last = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_ready", {31'b0, o_ready}, 1);
    check("rst_outs", {27'b0, o_chip, o_symbol, o_sym_valid, o_busy, o_underrun}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    bq.delete(); bq.push_back(8'hA5);
    run_frame("single_a5", bq, 1'b1);

    bq.delete(); bq.push_back(8'h00); bq.push_back(8'hFF);
    run_frame("two_byte", bq, 1'b1);

    bq.delete(); bq.push_back(8'($urandom));
    run_frame("underrun", bq, 1'b0);

    for (int f = 0; f < 6; f++) begin
      bq.delete();
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) bq.push_back(8'($urandom));
      run_frame("rand_frame", bq, 1'b1);
    end

    // back-to-back: second frame offered during the gap
    clear_runs();
    und_q.delete();
    a = 8'($urandom);
    b = 8'($urandom);
    send_byte(a, 1'b1, hs);
    t = 0;
    while (runs_q.size() < 1 && t < 2000) begin
      tick();
      t++;
    end
    send_byte(b, 1'b1, hs);
    check("b2b_busy_in_gap", {31'b0, o_busy}, 1);
    wait_idle();
    check("b2b_runs", runs_q.size(), 2);
    if (runs_q.size() == 2) begin
      check("b2b_len0", runs_q[0], 192);
      check("b2b_len1", runs_q[1], 192);
      check("b2b_gap", start_q[1] - end_q[0], 33);
    end
    bq.delete(); bq.push_back(a);
    build_exp(bq, 16, 4);
    tmp_q = exp_q;
    bq.delete(); bq.push_back(b);
    build_exp(bq, 16, 4);
    exp_q = {tmp_q, exp_q};
    cmp_chips("b2b", chips_q);
    check("b2b_underruns", und_q.size(), 0);

    // asynchronous reset in the middle of the data phase
    clear_runs();
    und_q.delete();
    send_byte(8'h3C, 1'b0, hs);
    send_byte(8'hC3, 1'b1, hs);
    t = 0;
    while (chips_q.size() < 160 && t < 2000) begin
      tick();
      t++;
    end
    check("mid_data_reached", {31'b0, o_sym_valid}, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_outs", {27'b0, o_chip, o_symbol, o_sym_valid, o_busy, o_underrun}, 32'h0);
    check("async_rst_ready", {31'b0, o_ready}, 1);
    repeat (2) @(negedge clk);
    clear_runs();
    i_data = 8'h5A; i_last = 1'b1; i_valid = 1'b1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    hs = ncyc;
    i_valid = 1'b0; i_last = 1'b0;
    check("first_edge_accept", {31'b0, o_ready}, 0);
    wait_idle();
    check("post_rst_runs", runs_q.size(), 1);
    if (runs_q.size() > 0) begin
      check("post_rst_len", runs_q[0], 192);
      check("post_rst_start", start_q[0], hs + 2);
    end
    bq.delete(); bq.push_back(8'h5A);
    build_exp(bq, 16, 4);
    cmp_chips("post_rst", chips_q);
    check("post_rst_underruns", und_q.size(), 0);

    // SPC=2, PRE_LEN=1 instance
    b_chips.delete();
    b_runs.delete();
    a = 8'($urandom);
    @(negedge clk);
    check("b_ready", {31'b0, b_ready}, 1);
    b_data = a; b_last = 1'b1; b_valid = 1'b1;
    @(posedge clk);
    #1;
    b_valid = 1'b0; b_last = 1'b0;
    t = 0;
    while ((b_runs.size() < 1 || b_busy) && t < 500) begin
      tick();
      t++;
    end
    check("b_runs", b_runs.size(), 1);
    if (b_runs.size() > 0) check("b_len", b_runs[0], 36);
    bq.delete(); bq.push_back(a);
    build_exp(bq, 1, 2);
    cmp_chips("b_frame", b_chips);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
